// File: rtl/sc_arc_pkg.sv
// Shared constants for the ARC/SPARC-subset hard-wired controller:
// state encodings, register select codes, ALU opcodes and IR field values.
package sc_arc_pkg;

  localparam int DATAWIDTH_DECODER_SELECTION = 6;
  localparam int DATAWIDTH_MUX_SELECTION     = 6;
  localparam int DATAWIDTH_ALU_SELECTION     = 4;

  typedef enum logic [4:0] {
    ST_INIT      = 5'd0,
    ST_FETCH     = 5'd1,
    ST_DECODE    = 5'd2,
    ST_SETHI     = 5'd3,
    ST_BR_DISP   = 5'd4,
    ST_BR_ADD    = 5'd5,
    ST_CALL_DISP = 5'd6,
    ST_CALL_LINK = 5'd7,
    ST_CALL_ADD  = 5'd8,
    ST_SIMM      = 5'd9,
    ST_ALU       = 5'd10,
    ST_JMPL_LINK = 5'd11,
    ST_JMPL_PC   = 5'd12,
    ST_MEM_ADDR  = 5'd13,
    ST_LD        = 5'd14,
    ST_ST        = 5'd15,
    ST_INCPC     = 5'd16,
    ST_HALT      = 5'd17
  } state_t;

  localparam logic [5:0] REG_R0   = 6'd0;
  localparam logic [5:0] REG_R15  = 6'd15;
  localparam logic [5:0] REG_PC   = 6'd32;
  localparam logic [5:0] REG_IR   = 6'd33;
  localparam logic [5:0] REG_T0   = 6'd34;
  localparam logic [5:0] REG_T1   = 6'd35;
  localparam logic [5:0] REG_T2   = 6'd36;
  localparam logic [5:0] REG_T3   = 6'd37;
  localparam logic [5:0] REG_NONE = 6'd63;

  localparam logic [3:0] ALU_ANDCC    = 4'd0;
  localparam logic [3:0] ALU_ORCC     = 4'd1;
  localparam logic [3:0] ALU_ORNCC    = 4'd2;
  localparam logic [3:0] ALU_ADDCC    = 4'd3;
  localparam logic [3:0] ALU_SRL      = 4'd4;
  localparam logic [3:0] ALU_AND      = 4'd5;
  localparam logic [3:0] ALU_OR       = 4'd6;
  localparam logic [3:0] ALU_ORN      = 4'd7;
  localparam logic [3:0] ALU_ADD      = 4'd8;
  localparam logic [3:0] ALU_LSHIFT10 = 4'd9;
  localparam logic [3:0] ALU_SEXT13   = 4'd10;
  localparam logic [3:0] ALU_DISP22   = 4'd11;
  localparam logic [3:0] ALU_DISP30   = 4'd12;
  localparam logic [3:0] ALU_INCPC    = 4'd13;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_MEMORY = 2'b11;

  localparam logic [2:0] OP2_SETHI  = 3'b100;
  localparam logic [2:0] OP2_BRANCH = 3'b010;

  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_ANDCC = 6'b010001;
  localparam logic [5:0] OP3_ORCC  = 6'b010010;
  localparam logic [5:0] OP3_ORNCC = 6'b010110;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;

  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;

  // r0 is hard-wired zero, so a write aimed at it becomes "no write".
  function automatic logic [5:0] dest_reg(input logic [4:0] rd);
    return (rd == 5'd0) ? REG_NONE : {1'b0, rd};
  endfunction

endpackage

// File: rtl/sc_branch_eval.sv
// Branch condition evaluator: condition code plus active-low PSR flags to taken.
module sc_branch_eval
  import sc_arc_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic       i_negative_n,
  input  logic       i_zero_n,
  input  logic       i_overflow_n,
  input  logic       i_carry_n,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_BE:   o_taken = ~i_zero_n;
      COND_BCS:  o_taken = ~i_carry_n;
      COND_BNEG: o_taken = ~i_negative_n;
      COND_BVS:  o_taken = ~i_overflow_n;
      COND_BA:   o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_microsequencer.sv
// Hard-wired fetch/decode/execute controller for the ARC/SPARC-subset datapath.
// Outputs are Moore decodes of state and IR fields; only FETCH/LD writes depend on ack.
module sc_microsequencer
  import sc_arc_pkg::*;
(
  input  logic                                   SC_MICROSEQUENCER_CLOCK_50,
  input  logic                                   SC_MICROSEQUENCER_Reset_InLow,
  input  logic [1:0]                             SC_MICROSEQUENCER_RegIR_OP,
  input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RD,
  input  logic [2:0]                             SC_MICROSEQUENCER_RegIR_OP2,
  input  logic [5:0]                             SC_MICROSEQUENCER_RegIR_OP3,
  input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RS1,
  input  logic                                   SC_MICROSEQUENCER_RegIR_BIT13,
  input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RS2,
  input  logic                                   SC_MICROSEQUENCER_Negative_InLow,
  input  logic                                   SC_MICROSEQUENCER_Zero_InLow,
  input  logic                                   SC_MICROSEQUENCER_Overflow_InLow,
  input  logic                                   SC_MICROSEQUENCER_Carry_InLow,
  input  logic                                   SC_MICROSEQUENCER_MemAck_In,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_MICROSEQUENCER_ALUSelection_Out,
  output logic                                   SC_MICROSEQUENCER_MemRead_Out,
  output logic                                   SC_MICROSEQUENCER_MemWrite_Out,
  output logic                                   SC_MICROSEQUENCER_FlagsLoad_Out,
  output logic                                   SC_MICROSEQUENCER_Illegal_Out
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_post_operand;
  logic       w_taken;
  logic       w_ack;
  logic [5:0] w_rd;
  logic [5:0] w_rs1;
  logic [5:0] w_opb;
  logic [3:0] w_arith_alu;
  logic       w_arith_ok;
  logic       w_arith_cc;
  logic       w_mem_ok;

  assign w_ack = SC_MICROSEQUENCER_MemAck_In;
  assign w_rd  = dest_reg(SC_MICROSEQUENCER_RegIR_RD);
  assign w_rs1 = {1'b0, SC_MICROSEQUENCER_RegIR_RS1};
  assign w_opb = SC_MICROSEQUENCER_RegIR_BIT13 ? REG_T0 : {1'b0, SC_MICROSEQUENCER_RegIR_RS2};

  sc_branch_eval u_branch_eval (
    .i_cond       (SC_MICROSEQUENCER_RegIR_RD[3:0]),
    .i_negative_n (SC_MICROSEQUENCER_Negative_InLow),
    .i_zero_n     (SC_MICROSEQUENCER_Zero_InLow),
    .i_overflow_n (SC_MICROSEQUENCER_Overflow_InLow),
    .i_carry_n    (SC_MICROSEQUENCER_Carry_InLow),
    .o_taken      (w_taken)
  );

  always_comb begin
    w_arith_ok  = 1'b1;
    w_arith_cc  = 1'b1;
    w_arith_alu = ALU_ADDCC;
    case (SC_MICROSEQUENCER_RegIR_OP3)
      OP3_ADDCC: w_arith_alu = ALU_ADDCC;
      OP3_ANDCC: w_arith_alu = ALU_ANDCC;
      OP3_ORCC:  w_arith_alu = ALU_ORCC;
      OP3_ORNCC: w_arith_alu = ALU_ORNCC;
      OP3_SRL: begin
        w_arith_alu = ALU_SRL;
        w_arith_cc  = 1'b0;
      end
      default: begin
        w_arith_ok = 1'b0;
        w_arith_cc = 1'b0;
      end
    endcase
  end

  assign w_mem_ok = (SC_MICROSEQUENCER_RegIR_OP3 == OP3_LD) || (SC_MICROSEQUENCER_RegIR_OP3 == OP3_ST);

  // SIMM re-derives its successor from the IR, which is stable through execution.
  always_comb begin
    w_post_operand = ST_ALU;
    if (SC_MICROSEQUENCER_RegIR_OP == OP_MEMORY)
      w_post_operand = ST_MEM_ADDR;
    else if (SC_MICROSEQUENCER_RegIR_OP3 == OP3_JMPL)
      w_post_operand = ST_JMPL_LINK;
  end

  always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50 or negedge SC_MICROSEQUENCER_Reset_InLow) begin
    if (!SC_MICROSEQUENCER_Reset_InLow)
      r_state <= ST_INIT;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next                                       = r_state;
    SC_MICROSEQUENCER_DecoderSelectionWrite_Out  = REG_NONE;
    SC_MICROSEQUENCER_MUXSelectionBUSA_Out       = REG_R0;
    SC_MICROSEQUENCER_MUXSelectionBUSB_Out       = REG_R0;
    SC_MICROSEQUENCER_ALUSelection_Out           = 4'd0;
    SC_MICROSEQUENCER_MemRead_Out                = 1'b0;
    SC_MICROSEQUENCER_MemWrite_Out               = 1'b0;
    SC_MICROSEQUENCER_FlagsLoad_Out              = 1'b0;
    SC_MICROSEQUENCER_Illegal_Out                = 1'b0;
    case (r_state)
      ST_INIT: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_PC;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_OR;
        w_next                                      = ST_FETCH;
      end
      ST_FETCH: begin
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_PC;
        SC_MICROSEQUENCER_MemRead_Out               = 1'b1;
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = w_ack ? REG_IR : REG_NONE;
        if (w_ack) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_next = ST_HALT;
        case (SC_MICROSEQUENCER_RegIR_OP)
          OP_BRANCH: begin
            if (SC_MICROSEQUENCER_RegIR_OP2 == OP2_SETHI)
              w_next = ST_SETHI;
            else if (SC_MICROSEQUENCER_RegIR_OP2 == OP2_BRANCH)
              w_next = w_taken ? ST_BR_DISP : ST_INCPC;
          end
          OP_CALL: w_next = ST_CALL_DISP;
          OP_ARITH: begin
            if (w_arith_ok || SC_MICROSEQUENCER_RegIR_OP3 == OP3_JMPL)
              w_next = SC_MICROSEQUENCER_RegIR_BIT13 ? ST_SIMM : w_post_operand;
          end
          default: begin
            if (w_mem_ok)
              w_next = SC_MICROSEQUENCER_RegIR_BIT13 ? ST_SIMM : w_post_operand;
          end
        endcase
      end
      ST_SETHI: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = w_rd;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_IR;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_LSHIFT10;
        w_next                                      = ST_INCPC;
      end
      ST_BR_DISP: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_T0;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_IR;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_DISP22;
        w_next                                      = ST_BR_ADD;
      end
      ST_BR_ADD, ST_CALL_ADD: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_PC;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_PC;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = REG_T0;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_ADD;
        w_next                                      = ST_FETCH;
      end
      ST_CALL_DISP: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_T0;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_IR;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_DISP30;
        w_next                                      = ST_CALL_LINK;
      end
      ST_CALL_LINK: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_R15;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_PC;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_OR;
        w_next                                      = ST_CALL_ADD;
      end
      ST_SIMM: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_T0;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_IR;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_SEXT13;
        w_next                                      = w_post_operand;
      end
      ST_ALU: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = w_rd;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = w_rs1;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = w_opb;
        SC_MICROSEQUENCER_ALUSelection_Out          = w_arith_alu;
        SC_MICROSEQUENCER_FlagsLoad_Out             = w_arith_cc;
        w_next                                      = ST_INCPC;
      end
      ST_JMPL_LINK: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = w_rd;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_PC;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_OR;
        w_next                                      = ST_JMPL_PC;
      end
      ST_JMPL_PC: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_PC;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = w_rs1;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = w_opb;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_ADD;
        w_next                                      = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_T1;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = w_rs1;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = w_opb;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_ADD;
        w_next = (SC_MICROSEQUENCER_RegIR_OP3 == OP3_LD) ? ST_LD : ST_ST;
      end
      ST_LD: begin
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_T1;
        SC_MICROSEQUENCER_MemRead_Out               = 1'b1;
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = w_ack ? w_rd : REG_NONE;
        if (w_ack) w_next = ST_INCPC;
      end
      ST_ST: begin
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out = REG_T1;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out = {1'b0, SC_MICROSEQUENCER_RegIR_RD};
        SC_MICROSEQUENCER_MemWrite_Out         = 1'b1;
        if (w_ack) w_next = ST_INCPC;
      end
      ST_INCPC: begin
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = REG_PC;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = REG_PC;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_INCPC;
        w_next                                      = ST_FETCH;
      end
      ST_HALT: begin
        SC_MICROSEQUENCER_Illegal_Out = 1'b1;
        w_next                        = ST_HALT;
      end
      default: w_next = ST_INIT;
    endcase
  end

endmodule
